// File: rtl/bus_loader.sv
// bus_loader: UART byte-stream command parser that issues one picorv32-style
// native memory request per W/R command and streams back a response.
//   'W' a0 a1 a2 a3 d0 d1 d2 d3 -> write, reply 'K'
//   'R' a0 a1 a2 a3             -> read, reply rdata[7:0] .. rdata[31:24]
//   other command byte          -> reply '?'
//   bus wait of TIMEOUT cycles  -> reply 'T'
module bus_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // Wait counter only has to hold 0..TIMEOUT-1.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_Q = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;       // byte index within ADDR/DATA field
  logic [1:0]    rcnt_q, rcnt_d;     // response byte index
  logic [1:0]    rlast_q, rlast_d;   // index of final response byte
  logic          wr_q, wr_d;         // 1 = write command
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;     // response bytes, little-endian
  logic [WW-1:0] wcnt_q, wcnt_d;     // cycles waited for mem_ready

  // Outputs decode straight from registered state, so the async reset
  // drops mem_valid/tx_valid/busy without waiting for a clock edge.
  assign mem_valid = (state_q == S_BUS);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (mem_valid && wr_q) ? 4'hF : 4'h0;
  assign tx_valid  = (state_q == S_RESP);
  assign tx_data   = resp_q[{rcnt_q, 3'b000} +: 8];
  assign busy      = (state_q != S_IDLE);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      rlast_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rlast_q <= rlast_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state: parse command bytes, run the bus request, stream response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    rlast_d = rlast_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (rx_data == CH_W) begin
            state_d = S_ADDR;
            wr_d    = 1'b1;
          end else if (rx_data == CH_R) begin
            state_d = S_ADDR;
            wr_d    = 1'b0;
          end else begin
            state_d = S_RESP;
            resp_d  = {24'h0, CH_Q};
            rlast_d = 2'd0;
            rcnt_d  = 2'd0;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          // Shift right so the first byte ends up in bits [7:0].
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = wr_q ? S_DATA : S_BUS;
            wcnt_d  = '0;
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            wcnt_d  = '0;
          end
        end
      end

      S_BUS: begin
        // Completion is checked before expiry so a ready on the last
        // permitted cycle still counts as a normal transfer.
        if (mem_ready) begin
          state_d = S_RESP;
          rcnt_d  = 2'd0;
          if (wr_q) begin
            resp_d  = {24'h0, CH_K};
            rlast_d = 2'd0;
          end else begin
            resp_d  = mem_rdata;
            rlast_d = 2'd3;
          end
        end else if (wcnt_q == WLAST) begin
          state_d = S_RESP;
          rcnt_d  = 2'd0;
          resp_d  = {24'h0, CH_T};
          rlast_d = 2'd0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          if (rcnt_q == rlast_q) begin
            state_d = S_IDLE;
            rcnt_d  = 2'd0;
          end else begin
            rcnt_d = rcnt_q + 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/bus_loader.md
BUS_LOADER -- requirements
Module: bus_loader

Interface
REQ-001 Parameter TIMEOUT, default 255; max cycles mem_valid may wait for mem_ready before abort.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 tx_data  output  8  response byte to UART transmitter.
REQ-007 tx_valid  output  1  tx_data valid; held until accepted.
REQ-008 tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready at clock edge.
REQ-009 mem_valid  output  1  bus request (picorv32 native memory protocol, initiator side).
REQ-010 mem_addr  output  32  word address; bits [1:0] always 0.
REQ-011 mem_wdata  output  32  write data.
REQ-012 mem_wstrb  output  4  4'hF for write, 4'h0 for read.
REQ-013 mem_ready  input  1  responder completion; may be combinational from mem_valid.
REQ-014 mem_rdata  input  32  read data, valid when mem_ready high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, ADDR, DATA, BUS, RESP; 2-bit byte counter cnt; 2-bit response counter rcnt.
REQ-017 IDLE: rx_valid with 0x57 ('W') -> ADDR, op=write, cnt=0; 0x52 ('R') -> ADDR, op=read, cnt=0; any other byte -> RESP with single response 0x3F ('?').
REQ-018 ADDR: each rx_valid shifts byte into address, little-endian (first byte = bits [7:0]); after 4th byte -> DATA if write, BUS if read.
REQ-019 DATA: each rx_valid shifts byte into wdata, little-endian; after 4th byte -> BUS.
REQ-020 BUS: mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_wdata, mem_wstrb stable for entire request.
REQ-021 Completion when mem_valid&mem_ready at clock edge; mem_valid SHALL be 0 the following cycle; read captures mem_rdata at that edge.
REQ-022 Wait counter starts at 0 on BUS entry, increments each cycle without mem_ready; on reaching TIMEOUT without completion, mem_valid drops next cycle and response is 0x54 ('T').
REQ-023 mem_ready on the same edge as timeout expiry SHALL count as completion, not timeout.
REQ-024 Responses: write complete -> 0x4B ('K'); read complete -> 4 bytes of captured rdata, little-endian; timeout -> 0x54; bad command -> 0x3F.
REQ-025 RESP: tx_valid=1 with current byte; on tx_valid&tx_ready advance rcnt; after last byte accepted -> IDLE, tx_valid=0 next cycle.
REQ-026 tx_data SHALL NOT change while tx_valid high and tx_ready low.
REQ-027 rx_valid in BUS or RESP SHALL be ignored (byte dropped, no state change).
REQ-028 mem_valid SHALL never assert outside BUS; exactly one bus request per W/R command.
REQ-029 mem_rdata ignored when mem_ready low; mem_ready ignored when mem_valid low.

Reset
REQ-030 resetn low SHALL immediately (asynchronously) force IDLE, mem_valid=0, tx_valid=0, busy=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, tx_data=0, all counters 0.
REQ-031 Reset mid-transaction SHALL abandon the command; no response byte after release.
REQ-032 First rx_valid accepted is the first edge with resetn high.

Verification
REQ-033 Write: bytes 57 10 00 00 10 EF BE AD DE, mem_ready 1 cycle after mem_valid -> one request addr 0x10000010, wdata 0xDEADBEEF, wstrb F; response 4B.
REQ-034 Read: bytes 52 04 00 00 00, mem_rdata=0x12345678 with mem_ready -> addr 0x00000004, wstrb 0; response 78 56 34 12; tx_ready toggled 1/0 shows tx_data stable while stalled.
REQ-035 Unaligned/bad: bytes 52 07 00 00 00 -> addr 0x00000004; then byte 41 -> response 3F, no bus request.
REQ-036 Timeout: read, mem_ready held 0 -> mem_valid high exactly TIMEOUT cycles then low; response 54; mem_ready asserted on expiry edge instead -> normal read response.
REQ-037 Reset: resetn pulsed low during BUS and during RESP -> mem_valid/tx_valid drop without clock edge; after release, no stray response; next W command completes normally.
REQ-038 Dropped bytes: rx_valid bursts during BUS/RESP -> ignored; subsequent command parsed from IDLE correctly.
